// File: rtl/arm_run_ctrl.sv
`timescale 1ns/1ps
// Run/step/breakpoint sequencer driving the ARM core's reset and global pipeline enable.
// Optional breakpoint logic is compiled in when RUN_CTRL_BKPT_EN is defined.
module arm_run_ctrl #(
   parameter int RST_HOLD_CYCLES = 16,
   parameter int STEP_CYCLES     = 1,
   parameter int CNT_W           = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             run_req,
   input  logic             step_req,
   input  logic             halt_req,
   input  logic [31:0]      if_pc,
   input  logic [31:0]      bkpt_addr,
   input  logic             bkpt_valid,
   output logic             cpu_rst,
   output logic             cpu_en,
   output logic             halted,
   output logic [1:0]       state,
   output logic             step_done,
   output logic             bkpt_hit,
   output logic [CNT_W-1:0] cycle_cnt
);

   typedef enum logic [1:0] {
      S_RST_HOLD = 2'd0,
      S_HALT     = 2'd1,
      S_RUN      = 2'd2,
      S_STEP     = 2'd3
   } state_t;

   localparam int HOLD_W = (RST_HOLD_CYCLES < 2) ? 1 : $clog2(RST_HOLD_CYCLES + 1);
   localparam int STEP_W = (STEP_CYCLES < 2) ? 1 : $clog2(STEP_CYCLES + 1);
   localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(RST_HOLD_CYCLES - 1);
   localparam logic [STEP_W-1:0] STEP_LOAD = STEP_W'(STEP_CYCLES);
   localparam logic [STEP_W-1:0] STEP_ONE  = STEP_W'(1);

   state_t              state_r;
   state_t              state_nxt_s;
   logic [HOLD_W-1:0]   hold_cnt_r;
   logic [HOLD_W-1:0]   hold_cnt_nxt_s;
   logic [STEP_W-1:0]   step_cnt_r;
   logic [STEP_W-1:0]   step_cnt_nxt_s;
   logic                skip_r;
   logic                skip_nxt_s;
   logic                step_done_nxt_s;
   logic                bkpt_match_s;
   logic                cpu_rst_r;
   logic                halted_r;
   logic                step_done_r;
   logic                bkpt_hit_r;
   logic [CNT_W-1:0]    cycle_cnt_r;

`ifdef RUN_CTRL_BKPT_EN
   // The skip flag keeps the resume cycle from re-stopping on the frozen breakpoint PC.
   assign bkpt_match_s = bkpt_valid && (if_pc == bkpt_addr) && (state_r == S_RUN) && !skip_r;
`else
   logic unused_bkpt_s;
   assign unused_bkpt_s = ^{if_pc, bkpt_addr, bkpt_valid, skip_r};
   assign bkpt_match_s  = 1'b0;
`endif

   assign cpu_en    = ((state_r == S_RUN) && !bkpt_match_s) || (state_r == S_STEP);
   assign cpu_rst   = cpu_rst_r;
   assign halted    = halted_r;
   assign state     = state_r;
   assign step_done = step_done_r;
   assign bkpt_hit  = bkpt_hit_r;
   assign cycle_cnt = cycle_cnt_r;

   // Next-state and counter update logic.
   always_comb begin
      state_nxt_s     = state_r;
      hold_cnt_nxt_s  = hold_cnt_r;
      step_cnt_nxt_s  = step_cnt_r;
      skip_nxt_s      = skip_r;
      step_done_nxt_s = 1'b0;
      case (state_r)
         S_RST_HOLD: begin
            if (hold_cnt_r == HOLD_LAST) begin
               state_nxt_s    = S_HALT;
               hold_cnt_nxt_s = '0;
            end else begin
               hold_cnt_nxt_s = hold_cnt_r + HOLD_W'(1);
            end
         end
         S_HALT: begin
            if (run_req) begin
               state_nxt_s = S_RUN;
               skip_nxt_s  = 1'b1;
            end else if (step_req) begin
               state_nxt_s    = S_STEP;
               step_cnt_nxt_s = STEP_LOAD;
            end else begin
               state_nxt_s = S_HALT;
            end
         end
         S_RUN: begin
            skip_nxt_s = 1'b0;
            if (halt_req || bkpt_match_s) begin
               state_nxt_s = S_HALT;
            end else begin
               state_nxt_s = S_RUN;
            end
         end
         S_STEP: begin
            if (halt_req) begin
               state_nxt_s    = S_HALT;
               step_cnt_nxt_s = '0;
            end else if (step_cnt_r == STEP_ONE) begin
               state_nxt_s     = S_HALT;
               step_cnt_nxt_s  = '0;
               step_done_nxt_s = 1'b1;
            end else begin
               step_cnt_nxt_s = step_cnt_r - STEP_ONE;
            end
         end
         default: begin
            state_nxt_s = S_RST_HOLD;
         end
      endcase
   end

   // State, counters and registered outputs.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_r     <= S_RST_HOLD;
         hold_cnt_r  <= '0;
         step_cnt_r  <= '0;
         skip_r      <= 1'b0;
         cpu_rst_r   <= 1'b1;
         halted_r    <= 1'b0;
         step_done_r <= 1'b0;
         bkpt_hit_r  <= 1'b0;
         cycle_cnt_r <= '0;
      end else begin
         state_r     <= state_nxt_s;
         hold_cnt_r  <= hold_cnt_nxt_s;
         step_cnt_r  <= step_cnt_nxt_s;
         skip_r      <= skip_nxt_s;
         cpu_rst_r   <= (state_nxt_s == S_RST_HOLD);
         halted_r    <= (state_nxt_s == S_HALT);
         step_done_r <= step_done_nxt_s;
         bkpt_hit_r  <= bkpt_match_s;
         cycle_cnt_r <= cycle_cnt_r + CNT_W'(cpu_en);
      end
   end

endmodule
